// File: rtl/div_sched.sv
// div_sched: sequencer between EX and the shared multi-cycle divider.
// One op in flight, flush drain, one-entry operand/result cache.
module div_sched #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [2:0]   req_op,
    input  logic [63:0]  req_rs1,
    input  logic [63:0]  req_rs2,
    output logic         req_ready,
    input  logic         flush,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [63:0]  resp_data,
    output logic         busy,
    output logic         div_valid,
    output logic         div_sign,
    output logic         div_32,
    output logic [63:0]  div_rs1,
    output logic [63:0]  div_rs2,
    input  logic         div_ready,
    input  logic [127:0] div_result
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic           sign_q, sign_d;
    logic           w_q, w_d;
    logic           rem_q, rem_d;
    logic [63:0]    rs1_q, rs1_d;
    logic [63:0]    rs2_q, rs2_d;
    logic [63:0]    resp_data_q, resp_data_d;
    logic           cache_valid_q, cache_valid_d;
    logic [63:0]    cache_rs1_q, cache_rs1_d;
    logic [63:0]    cache_rs2_q, cache_rs2_d;
    logic           cache_w_q, cache_w_d;
    logic           cache_sign_q, cache_sign_d;
    logic [127:0]   cache_res_q, cache_res_d;

    logic           accept;
    logic           hit;

    function automatic logic [63:0] sel_res(
        input logic [127:0] res,
        input logic         rem,
        input logic         w
    );
        logic [63:0] r;
        r = rem ? res[127:64] : res[63:0];
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    assign req_ready  = (state_q == IDLE) & ~flush;
    assign div_valid  = (state_q == BUSY) | (state_q == DRAIN);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = resp_data_q;
    assign div_sign   = sign_q;
    assign div_32     = w_q;
    assign div_rs1    = rs1_q;
    assign div_rs2    = rs2_q;

    assign accept = req_valid & req_ready;
    assign hit    = CACHE_EN && cache_valid_q
                  && (req_rs1 == cache_rs1_q)
                  && (req_rs2 == cache_rs2_q)
                  && (req_op[2] == cache_w_q)
                  && (~req_op[0] == cache_sign_q);

    // Next-state, operand latch, cache update and result select
    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        w_d           = w_q;
        rem_d         = rem_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        resp_data_d   = resp_data_q;
        cache_valid_d = cache_valid_q;
        cache_rs1_d   = cache_rs1_q;
        cache_rs2_d   = cache_rs2_q;
        cache_w_d     = cache_w_q;
        cache_sign_d  = cache_sign_q;
        cache_res_d   = cache_res_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d = ~req_op[0];
                    w_d    = req_op[2];
                    rem_d  = req_op[1];
                    rs1_d  = req_rs1;
                    rs2_d  = req_rs2;
                    if (hit) begin
                        resp_data_d = sel_res(cache_res_q, req_op[1], req_op[2]);
                        state_d     = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY, DRAIN: begin
                if (div_ready) begin
                    // A killed op still yields a correct result worth keeping
                    cache_valid_d = 1'b1;
                    cache_rs1_d   = rs1_q;
                    cache_rs2_d   = rs2_q;
                    cache_w_d     = w_q;
                    cache_sign_d  = sign_q;
                    cache_res_d   = div_result;
                    if (state_q == DRAIN || flush) begin
                        state_d = IDLE;
                    end else begin
                        resp_data_d = sel_res(div_result, rem_q, w_q);
                        state_d     = DONE;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sign_q        <= 1'b0;
            w_q           <= 1'b0;
            rem_q         <= 1'b0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            resp_data_q   <= '0;
            cache_valid_q <= 1'b0;
            cache_rs1_q   <= '0;
            cache_rs2_q   <= '0;
            cache_w_q     <= 1'b0;
            cache_sign_q  <= 1'b0;
            cache_res_q   <= '0;
        end else begin
            state_q       <= state_d;
            sign_q        <= sign_d;
            w_q           <= w_d;
            rem_q         <= rem_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            resp_data_q   <= resp_data_d;
            cache_valid_q <= cache_valid_d;
            cache_rs1_q   <= cache_rs1_d;
            cache_rs2_q   <= cache_rs2_d;
            cache_w_q     <= cache_w_d;
            cache_sign_q  <= cache_sign_d;
            cache_res_q   <= cache_res_d;
        end
    end

endmodule
